// File: rtl/systolic_sequencer_pkg.sv
// Shared constants for the systolic array sequencer: instruction field layout,
// opcodes and controller states.
package systolic_seq_pkg;

  localparam int OPC_MSB  = 63;
  localparam int OPC_LSB  = 60;
  localparam int ADDR_MSB = 59;
  localparam int ADDR_LSB = 44;
  localparam int LEN_MSB  = 43;
  localparam int LEN_LSB  = 32;

  localparam logic [3:0] OPC_NOP     = 4'd0;
  localparam logic [3:0] OPC_LOAD_W  = 4'd1;
  localparam logic [3:0] OPC_LOAD_A  = 4'd2;
  localparam logic [3:0] OPC_COMPUTE = 4'd3;
  localparam logic [3:0] OPC_STORE   = 4'd4;
  localparam logic [3:0] OPC_HALT    = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_LOAD_W,
    S_LOAD_A,
    S_COMPUTE,
    S_STORE,
    S_HALT
  } state_t;

  function automatic logic is_data_op(input logic [3:0] opc);
    return (opc == OPC_LOAD_W) || (opc == OPC_LOAD_A) ||
           (opc == OPC_COMPUTE) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/systolic_sequencer_if.sv
// Instruction handshake, scratchpad strobes and array enables of the sequencer.
// SEQ_PERF_COUNTERS_EN adds the two performance counter outputs.
interface systolic_sequencer_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [63:0]           instr_in;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  mem_stall;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd_en;
  logic                  mem_wr_en;
  logic                  weight_load_en;
  logic                  act_load_en;
  logic                  compute_en;
  logic                  drain_en;
  logic                  busy;
  logic                  halted;
  logic                  err_illegal;

`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0] perf_compute_cycles;
  logic [31:0] perf_stall_cycles;

  modport master (
    input  instr_in, instr_valid, mem_stall,
    output instr_ready, mem_addr, mem_rd_en, mem_wr_en, weight_load_en,
           act_load_en, compute_en, drain_en, busy, halted, err_illegal,
           perf_compute_cycles, perf_stall_cycles
  );
  modport slave (
    output instr_in, instr_valid, mem_stall,
    input  instr_ready, mem_addr, mem_rd_en, mem_wr_en, weight_load_en,
           act_load_en, compute_en, drain_en, busy, halted, err_illegal,
           perf_compute_cycles, perf_stall_cycles
  );
`else
  modport master (
    input  instr_in, instr_valid, mem_stall,
    output instr_ready, mem_addr, mem_rd_en, mem_wr_en, weight_load_en,
           act_load_en, compute_en, drain_en, busy, halted, err_illegal
  );
  modport slave (
    output instr_in, instr_valid, mem_stall,
    input  instr_ready, mem_addr, mem_rd_en, mem_wr_en, weight_load_en,
           act_load_en, compute_en, drain_en, busy, halted, err_illegal
  );
`endif

endinterface

// File: rtl/systolic_sequencer_beat_counter.sv
// Loadable down-counter; holds while stalled, stops at zero.
// zero/last flags are decoded combinationally from the count.
module seq_beat_counter #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             stall,
  output logic             last,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !stall && !zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
  assign last = (count == WIDTH'(1));

endmodule

// File: rtl/systolic_sequencer.sv
// Decodes buffered instructions and sequences the PE array through load/compute/drain.
// Two cycles of overhead per instruction; mem_stall freezes a phase with all strobes low.
// SEQ_PERF_COUNTERS_EN adds saturating compute/stall cycle counters.
module systolic_sequencer
  import systolic_seq_pkg::*;
#(
  parameter int ARRAY_DIM  = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 12
) (
  input logic                 clk,
  input logic                 rst,
  systolic_sequencer_if.master bus
);

  localparam int CW = LEN_WIDTH + 1;

  state_t                   state;
  logic [3:0]               opc_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [ADDR_WIDTH-1:0]    shown_q;
  logic [ADDR_WIDTH-1:0]    mem_addr_int;
  logic [LEN_WIDTH-1:0]     len_q;
  logic                     dly_q;
  logic                     err_q;

  logic [ADDR_MSB-ADDR_LSB:0] base_field;
  logic [LEN_MSB-LEN_LSB:0]   len_field;
  logic                       unused_bits;

  logic          in_load, in_phase, rd_beat, wr_beat, cmp_beat, beat, fire, stall_hold;
  logic          cnt_load, cnt_last, cnt_zero;
  logic [CW-1:0] cnt_load_val, compute_len;

  assign base_field  = bus.instr_in[ADDR_MSB:ADDR_LSB];
  assign len_field   = bus.instr_in[LEN_MSB:LEN_LSB];
  assign unused_bits = ^bus.instr_in[LEN_LSB-1:0];

  assign in_load    = (state == S_LOAD_W) || (state == S_LOAD_A);
  assign in_phase   = in_load || (state == S_COMPUTE) || (state == S_STORE);
  assign rd_beat    = in_load && !cnt_zero;
  assign wr_beat    = (state == S_STORE) && !cnt_zero;
  assign cmp_beat   = (state == S_COMPUTE) && !cnt_zero;
  assign beat       = rd_beat || wr_beat || cmp_beat;
  assign fire       = beat && !bus.mem_stall;
  assign stall_hold = bus.mem_stall && in_phase;

  // Fill + flush adds 2*(ARRAY_DIM-1) cycles; one extra bit keeps it from wrapping.
  assign compute_len  = {1'b0, len_q} + CW'(2 * ARRAY_DIM - 2);
  assign cnt_load     = (state == S_DECODE);
  assign cnt_load_val = (opc_q == OPC_COMPUTE) ? compute_len : {1'b0, len_q};

  seq_beat_counter #(.WIDTH(CW)) u_beat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (beat),
    .stall    (bus.mem_stall),
    .last     (cnt_last),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      opc_q   <= '0;
      addr_q  <= '0;
      shown_q <= '0;
      len_q   <= '0;
      dly_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      shown_q <= mem_addr_int;
      if (!stall_hold) dly_q <= rd_beat;
      if (fire && (state != S_COMPUTE)) addr_q <= addr_q + 1'b1;

      case (state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            opc_q  <= bus.instr_in[OPC_MSB:OPC_LSB];
            addr_q <= base_field[ADDR_WIDTH-1:0];
            len_q  <= len_field[LEN_WIDTH-1:0];
            state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (opc_q == OPC_HALT) begin
            state <= S_HALT;
          end else if (!is_data_op(opc_q)) begin
            if (opc_q != OPC_NOP) err_q <= 1'b1;
            state <= S_IDLE;
          end else if (len_q == '0) begin
            state <= S_IDLE;
          end else begin
            case (opc_q)
              OPC_LOAD_W:  state <= S_LOAD_W;
              OPC_LOAD_A:  state <= S_LOAD_A;
              OPC_COMPUTE: state <= S_COMPUTE;
              default:     state <= S_STORE;
            endcase
          end
        end
        // The extra cycle after the last read lets the delayed load enable fire.
        S_LOAD_W, S_LOAD_A: begin
          if (!bus.mem_stall && cnt_zero) state <= S_IDLE;
        end
        S_COMPUTE, S_STORE: begin
          if (fire && cnt_last) state <= S_IDLE;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_addr_int       = stall_hold ? shown_q : addr_q;
  assign bus.mem_addr       = mem_addr_int;
  assign bus.instr_ready    = (state == S_IDLE) && !rst;
  assign bus.mem_rd_en      = rd_beat && !bus.mem_stall;
  assign bus.mem_wr_en      = wr_beat && !bus.mem_stall;
  assign bus.drain_en       = wr_beat && !bus.mem_stall;
  assign bus.compute_en     = cmp_beat && !bus.mem_stall;
  assign bus.weight_load_en = dly_q && (state == S_LOAD_W) && !bus.mem_stall;
  assign bus.act_load_en    = dly_q && (state == S_LOAD_A) && !bus.mem_stall;
  assign bus.busy           = (state != S_IDLE);
  assign bus.halted         = (state == S_HALT);
  assign bus.err_illegal    = err_q;

`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0] perf_comp_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_comp_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (cmp_beat && !bus.mem_stall && (perf_comp_q != '1)) perf_comp_q <= perf_comp_q + 1'b1;
      if (stall_hold && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign bus.perf_compute_cycles = perf_comp_q;
  assign bus.perf_stall_cycles   = perf_stall_q;
`endif

endmodule
